mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: alternating priority on contention, one request per
// two cycles, with address range/alignment checking and registered responses.
module mem_arbiter #(
  parameter int unsigned NUM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] address,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  localparam logic [0:0]  IDLE       = 1'b0;
  localparam logic [0:0]  ACCESS     = 1'b1;
  localparam logic [31:0] WORD_LIMIT = 32'(NUM_WORDS);

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic        last_grant;
  logic        port_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        pick1_c;
  logic        accept_c;
  logic        req_ok_c;
  logic [31:0] load_data_c;

  // Port 1 wins when alone, or on contention when port 0 was granted last.
  always_comb begin
    pick1_c    = req1_valid & (~req0_valid | ~last_grant);
    accept_c   = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = (state == IDLE) & req0_valid & ~pick1_c;
    req1_ready = (state == IDLE) & pick1_c;
  end

  always_comb begin
    req_ok_c    = (addr_q[1:0] == 2'b00) && ({2'b00, addr_q[31:2]} < WORD_LIMIT);
    load_data_c = (req_ok_c && !write_q) ? readData : 32'h0;
  end

  // Strobes are killed by reset so a store cannot commit during a reset cycle.
  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) state_next = ACCESS;
      end
      ACCESS: begin
        MemRead    = req_ok_c & ~write_q & ~reset;
        MemWrite   = req_ok_c & write_q & ~reset;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign address   = addr_q;
  assign writeData = wdata_q;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture and response registers; other port's response holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      write_q    <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (accept_c) begin
        port_q     <= pick1_c;
        last_grant <= pick1_c;
        write_q    <= pick1_c ? req1_write : req0_write;
        addr_q     <= pick1_c ? req1_addr  : req0_addr;
        wdata_q    <= pick1_c ? req1_wdata : req0_wdata;
      end
      if (state == ACCESS) begin
        if (port_q) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= load_data_c;
          rsp1_err   <= ~req_ok_c;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= load_data_c;
          rsp0_err   <= ~req_ok_c;
        end
      end
    end
  end

endmodule
